// File: rtl/common.sv
// Shared drawing-pipeline definitions: color encoding and the state type
// used by shape rasterizers that feed drawing_canvas.
package common;

  localparam int COLOR_WIDTH = 3;

  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE    = 3'd0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED     = 3'd1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN   = 3'd2;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE    = 3'd3;
  localparam logic [COLOR_WIDTH-1:0] COLOR_YELLOW  = 3'd4;
  localparam logic [COLOR_WIDTH-1:0] COLOR_CYAN    = 3'd5;
  localparam logic [COLOR_WIDTH-1:0] COLOR_MAGENTA = 3'd6;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE   = 3'd7;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_SETUP = 2'd1,
    RS_DRAW  = 2'd2,
    RS_DONE  = 2'd3
  } raster_state_t;

endpackage

// File: rtl/line_rasterizer.sv
// Integer Bresenham line rasterizer: accepts one segment command and emits one
// inclusive-endpoint canvas write per clock on the drawing_canvas tool port.
module line_rasterizer
  import common::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [XW-1:0]          x0,
  input  logic [XW-1:0]          x1,
  input  logic [YW-1:0]          y0,
  input  logic [YW-1:0]          y1,
  input  logic [COLOR_WIDTH-1:0] color,
  output logic                   ready,
  output logic                   done,
  output logic                   enable,
  output logic [XW-1:0]          tool_x,
  output logic [YW-1:0]          tool_y,
  output logic [COLOR_WIDTH-1:0] tool_color
);

  localparam int MW = ((XW > YW) ? XW : YW) + 1;
  localparam int EW = MW + 1;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
    return (v > XMAX) ? XMAX : v;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
    return (v > YMAX) ? YMAX : v;
  endfunction

  function automatic logic signed [MW-1:0] ext_x(input logic [XW-1:0] v);
    return signed'({{(MW-XW){1'b0}}, v});
  endfunction

  function automatic logic signed [MW-1:0] ext_y(input logic [YW-1:0] v);
    return signed'({{(MW-YW){1'b0}}, v});
  endfunction

  raster_state_t state, next_state;

  logic [XW-1:0]          cur_x, end_x;
  logic [YW-1:0]          cur_y, end_y;
  logic [COLOR_WIDTH-1:0] color_q;
  logic signed [MW-1:0]   dx, dy;
  logic signed [EW-1:0]   err;
  logic                   x_neg, y_neg;

  logic signed [MW-1:0]   dx_raw, dy_raw, adx, ady;
  logic signed [EW-1:0]   err_init, dx_w, dy_w, err_nxt;
  logic signed [EW:0]     e2, dx_e, dy_e;
  logic                   step_x, step_y, at_end;

  always_comb begin
    dx_raw   = ext_x(end_x) - ext_x(cur_x);
    dy_raw   = ext_y(end_y) - ext_y(cur_y);
    adx      = dx_raw[MW-1] ? -dx_raw : dx_raw;
    ady      = dy_raw[MW-1] ? -dy_raw : dy_raw;
    err_init = signed'({adx[MW-1], adx}) - signed'({ady[MW-1], ady});

    dx_w     = {dx[MW-1], dx};
    dy_w     = {dy[MW-1], dy};
    dx_e     = {{2{dx[MW-1]}}, dx};
    dy_e     = {{2{dy[MW-1]}}, dy};
    e2       = {err, 1'b0};
    step_x   = (e2 >= dy_e);
    step_y   = (e2 <= dx_e);
    err_nxt  = err + (step_x ? dy_w : '0) + (step_y ? dx_w : '0);
    at_end   = (cur_x == end_x) && (cur_y == end_y);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RS_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      RS_IDLE:  if (start) next_state = RS_SETUP;
      RS_SETUP: next_state = RS_DRAW;
      RS_DRAW:  if (at_end) next_state = RS_DONE;
      RS_DONE:  next_state = RS_IDLE;
      default:  next_state = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x   <= '0;
      cur_y   <= '0;
      end_x   <= '0;
      end_y   <= '0;
      color_q <= COLOR_NONE;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      x_neg   <= 1'b0;
      y_neg   <= 1'b0;
    end else begin
      unique case (state)
        RS_IDLE: if (start) begin
          cur_x   <= clamp_x(x0);
          cur_y   <= clamp_y(y0);
          end_x   <= clamp_x(x1);
          end_y   <= clamp_y(y1);
          color_q <= color;
        end
        RS_SETUP: begin
          dx    <= adx;
          dy    <= -ady;
          err   <= err_init;
          x_neg <= dx_raw[MW-1];
          y_neg <= dy_raw[MW-1];
        end
        // The end pixel is written in the cycle it is reached; no step after it.
        RS_DRAW: if (!at_end) begin
          if (step_x) cur_x <= x_neg ? cur_x - XW'(1) : cur_x + XW'(1);
          if (step_y) cur_y <= y_neg ? cur_y - YW'(1) : cur_y + YW'(1);
          err <= err_nxt;
        end
        default: ;
      endcase
    end
  end

  assign ready      = (state == RS_IDLE);
  assign done       = (state == RS_DONE);
  assign enable     = (state == RS_DRAW);
  assign tool_x     = cur_x;
  assign tool_y     = cur_y;
  assign tool_color = color_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer on a 10x8 canvas: a driver pushes
// expected writes/done edges, a monitor pops and compares them.
module tb_line_rasterizer;
  import common::*;

  localparam int W  = 10;
  localparam int H  = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [XW-1:0]          x0 = '0, x1 = '0;
  logic [YW-1:0]          y0 = '0, y1 = '0;
  logic [COLOR_WIDTH-1:0] color = COLOR_NONE;
  logic                   ready, done, enable;
  logic [XW-1:0]          tool_x;
  logic [YW-1:0]          tool_y;
  logic [COLOR_WIDTH-1:0] tool_color;

  line_rasterizer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .ready(ready), .done(done), .enable(enable),
    .tool_x(tool_x), .tool_y(tool_y), .tool_color(tool_color)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    int e;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  edge_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  logic clr = 1'b1;
  logic [COLOR_WIDTH-1:0] canvas [W][H];

  always @(posedge clk) edge_cnt++;

  // Canvas model: captures each write at the end of its cycle.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < W; i++)
        for (int j = 0; j < H; j++)
          canvas[i][j] <= COLOR_NONE;
    end else if (enable && int'(tool_x) < W && int'(tool_y) < H) begin
      canvas[tool_x][tool_y] <= tool_color;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected (%0d,%0d) color %0d at edge %0d", tool_x, tool_y, tool_color, edge_cnt);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          if (int'(tool_x) != w.x || int'(tool_y) != w.y || int'(tool_color) != w.c || edge_cnt != w.e) begin
            errors++;
            $display("FAIL write: got (%0d,%0d) c=%0d edge=%0d, want (%0d,%0d) c=%0d edge=%0d",
                     tool_x, tool_y, tool_color, edge_cnt, w.x, w.y, w.c, w.e);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done: unexpected pulse at edge %0d", edge_cnt);
        end else begin
          int de;
          de = done_q.pop_front();
          if (edge_cnt != de || ready !== 1'b0) begin
            errors++;
            $display("FAIL done: at edge %0d ready=%0b, want edge %0d ready=0", edge_cnt, ready, de);
          end
        end
      end
    end
  end

  // Reference: textbook Bresenham on clamped endpoints, k = accept edge.
  task automatic push_seg(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int c, input int k, output int n);
    int x, y, ex, ey, dx, dy, sx, sy, err, e2, i;
    x  = (ax0 > W-1) ? W-1 : ax0;
    y  = (ay0 > H-1) ? H-1 : ay0;
    ex = (ax1 > W-1) ? W-1 : ax1;
    ey = (ay1 > H-1) ? H-1 : ay1;
    dx = (ex > x) ? ex - x : x - ex;
    dy = (ey > y) ? y - ey : ey - y;
    sx = (ex >= x) ? 1 : -1;
    sy = (ey >= y) ? 1 : -1;
    err = dx + dy;
    i = 0;
    forever begin
      exp_q.push_back('{x, y, c, k + 1 + i});
      i++;
      if (x == ex && y == ey) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    n = i;
    done_q.push_back(k + n + 1);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic drive_cmd(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
    x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
    color = COLOR_WIDTH'(c);
  endtask

  task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                       input int c, output int k, output int n);
    wait_ready();
    drive_cmd(ax0, ay0, ax1, ay1, c);
    start = 1'b1;
    k = edge_cnt + 1;
    push_seg(ax0, ay0, ax1, ay1, c, k, n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || !ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size() + done_q.size(), 0);
  endtask

  task automatic wait_edge(input int target);
    int t = 0;
    while (edge_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    int k, n, ka, na, kb, nb;
    #3;
    check("rst_ready", ready, 1);
    check("rst_enable", enable, 0);
    check("rst_done", done, 0);
    check("rst_tool_x", tool_x, 0);
    check("rst_tool_y", tool_y, 0);
    check("rst_tool_color", tool_color, COLOR_NONE);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    clr = 1'b0;

    issue(0, 0, 3, 0, COLOR_BLUE, k, n);
    drain();
    for (int i = 0; i < 4; i++) check("horiz_cell", canvas[i][0], COLOR_BLUE);
    check("horiz_past_end", canvas[4][0], COLOR_NONE);

    issue(1, 0, 2, 5, COLOR_GREEN, k, n);
    drain();
    issue(5, 5, 2, 2, COLOR_RED, k, n);
    drain();
    check("rev_diag_cell", canvas[3][3], COLOR_RED);
    issue(3, 3, 3, 3, COLOR_WHITE, k, n);
    drain();
    issue(8, 1, 15, 1, COLOR_CYAN, k, n);
    drain();
    check("clamp_cell_9", canvas[9][1], COLOR_CYAN);

    // Start pulse while busy must be ignored.
    issue(0, 1, 9, 4, COLOR_YELLOW, k, n);
    wait_edge(k + 4);
    drive_cmd(6, 6, 1, 2, COLOR_MAGENTA);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Start held high: second command accepted exactly at ready rise.
    wait_ready();
    drive_cmd(2, 7, 7, 4, COLOR_GREEN);
    start = 1'b1;
    ka = edge_cnt + 1;
    push_seg(2, 7, 7, 4, COLOR_GREEN, ka, na);
    @(posedge clk);
    #1 drive_cmd(9, 0, 4, 2, COLOR_BLUE);
    kb = ka + na + 3;
    push_seg(9, 0, 4, 2, COLOR_BLUE, kb, nb);
    wait_edge(kb);
    start = 1'b0;
    drain();

    // Reset during the second write of a long segment.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    issue(0, 0, 7, 0, COLOR_RED, k, n);
    wait_edge(k + 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_enable", enable, 0);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_tool_x", tool_x, 0);
    check("midrst_tool_color", tool_color, COLOR_NONE);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("midrst_cell0", canvas[0][0], COLOR_RED);
    for (int i = 2; i < 8; i++) check("midrst_unwritten", canvas[i][0], COLOR_NONE);
    check("midrst_ready_after", ready, 1);
    issue(3, 1, 6, 3, COLOR_MAGENTA, k, n);
    drain();
    check("post_rst_cell", canvas[6][3], COLOR_MAGENTA);

    for (int r = 0; r < 30; r++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            int'($urandom_range(1, 7)), k, n);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
